spi_frame_feeder: RTL and testbench

//  Frame buffer that sits directly upstream of the SPI slave transmitter.
//  - Accepts 128-bit trace frames from the frame assembler; no backpressure is possible.
//  - Queues them in a small FIFO.
//  - Presents one frame at a time on Tx_packet; advances when the SPI stage requests the next frame.
//  - Presents IDLE_FRAME when no data is queued. Counts frames dropped because the FIFO was full.

---
 rtl/spi_frame_feeder.sv | 101 ++++++++++
 tb/tb_spi_frame_feeder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spi_frame_feeder.sv
// Frame buffer feeding the SPI slave transmitter: a small FIFO of 128-bit frames,
// one frame presented per request edge, IDLE_FRAME when empty, with drop statistics.
module spi_frame_feeder #(
   parameter int            ADDR_BITS  = 2,
   parameter logic [127:0]  IDLE_FRAME = {16{8'hA6}},
   parameter int            CNT_BITS   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [127:0]         FrameIn,
   input  logic                 FrameInValid,
   input  logic                 TxGetNext,
   input  logic                 ClrStats,
   output logic [127:0]         Tx_packet,
   output logic                 TxIsData,
   output logic [ADDR_BITS:0]   Level,
   output logic                 Overflow,
   output logic [CNT_BITS-1:0]  DropCount
);

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [127:0]         mem_q [DEPTH];
   logic [ADDR_BITS:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]   level_q, level_d;
   logic                 get_q, get_d;
   logic [127:0]         tx_packet_q, tx_packet_d;
   logic                 tx_is_data_q, tx_is_data_d;
   logic                 overflow_q, overflow_d;
   logic [CNT_BITS-1:0]  drop_cnt_q, drop_cnt_d;

   logic adv, empty, full, rd_en, wr_en, drop;

   always_comb begin
      adv   = TxGetNext & ~get_q;
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]) &&
              (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]);
      rd_en = adv & ~empty;
      // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
      wr_en = FrameInValid & (~full | rd_en);
      drop  = FrameInValid & ~wr_en;

      get_d        = TxGetNext;
      tx_packet_d  = tx_packet_q;
      tx_is_data_d = tx_is_data_q;
      if (adv) begin
         tx_packet_d  = empty ? IDLE_FRAME : mem_q[rd_ptr_q[ADDR_BITS-1:0]];
         tx_is_data_d = ~empty;
      end

      wr_ptr_d = wr_ptr_q + (ADDR_BITS+1)'(wr_en);
      rd_ptr_d = rd_ptr_q + (ADDR_BITS+1)'(rd_en);
      level_d  = wr_ptr_d - rd_ptr_d;

      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (ClrStats) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_BITS'(1);
      end
   end

   // Edge detector resets high so a request held across reset is not seen as new.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         get_q        <= 1'b1;
         tx_packet_q  <= IDLE_FRAME;
         tx_is_data_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         get_q        <= get_d;
         tx_packet_q  <= tx_packet_d;
         tx_is_data_q <= tx_is_data_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && wr_en) mem_q[wr_ptr_q[ADDR_BITS-1:0]] <= FrameIn;
   end

   assign Tx_packet = tx_packet_q;
   assign TxIsData  = tx_is_data_q;
   assign Level     = level_q;
   assign Overflow  = overflow_q;
   assign DropCount = drop_cnt_q;

endmodule

// File: tb/tb_spi_frame_feeder.sv
// Bench for spi_frame_feeder: directed vector table, hand sequences for request
// holding and counter saturation, then random traffic against a queue-based model.
module tb_spi_frame_feeder;

   localparam int CW = 8;
   localparam logic [127:0] IDLE = {16{8'hA6}};
   localparam logic [127:0] FX   = 128'h0FF1_2233_4455_6677_8899_AABB_CCDD_EE01;

   logic            clk = 1'b0;
   logic            rst, vld, get, clr;
   logic [127:0]    frm;
   logic [127:0]    tx;
   logic            dat, ov;
   logic [2:0]      lvl;
   logic [CW-1:0]   cnt;

   int nchk = 0;
   int nfail = 0;

   spi_frame_feeder #(.ADDR_BITS(2), .IDLE_FRAME(IDLE), .CNT_BITS(CW)) dut (
      .clk(clk), .rst(rst), .FrameIn(frm), .FrameInValid(vld), .TxGetNext(get),
      .Tx_packet(tx), .TxIsData(dat), .Level(lvl), .Overflow(ov),
      .DropCount(cnt), .ClrStats(clr)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of frames plus the presented frame and statistics.
   logic [127:0]  m_q[$];
   logic [127:0]  m_tx = IDLE;
   logic          m_dat = 1'b0, m_prev = 1'b1, m_ov = 1'b0;
   logic [CW-1:0] m_cnt = '0;

   function automatic logic [127:0] fr(input int k);
      logic [7:0] b;
      b = 8'h10 + 8'(k);
      return {16{b}};
   endfunction

   task automatic model_step();
      logic adv, popped;
      adv = get && !m_prev;
      m_prev = get;
      if (!rst) begin
         m_q.delete(); m_tx = IDLE; m_dat = 0; m_prev = 1; m_ov = 0; m_cnt = '0;
         return;
      end
      popped = 0;
      if (adv) begin
         if (m_q.size() > 0) begin m_tx = m_q.pop_front(); m_dat = 1; popped = 1; end
         else begin m_tx = IDLE; m_dat = 0; end
      end
      if (vld && m_q.size() < 4) m_q.push_back(frm);
      else if (vld && clr == 0) begin
         m_ov = 1;
         if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
      if (clr) begin m_ov = 0; m_cnt = '0; end
   endtask

   task automatic cyc(input logic r, v, input logic [127:0] f, input logic g, c);
      @(negedge clk);
      rst = r; vld = v; frm = f; get = g; clr = c;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic chk(input string nm, input int idx, input logic [127:0] act, exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s[%0d] got %h exp %h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic [127:0] etx, input logic edat,
                          input logic [2:0] elvl, input logic eov, input logic [CW-1:0] ecnt);
      chk("tx", idx, tx, etx);
      chk("isdata", idx, 128'(dat), 128'(edat));
      chk("level", idx, 128'(lvl), 128'(elvl));
      chk("overflow", idx, 128'(ov), 128'(eov));
      chk("dropcnt", idx, 128'(cnt), 128'(ecnt));
   endtask

   typedef struct {
      logic r, v; logic [127:0] f; logic g, c;
      logic [127:0] etx; logic edat; logic [2:0] elvl; logic eov; logic [CW-1:0] ecnt;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic r, v, input logic [127:0] f, input logic g, c,
                      input logic [127:0] etx, input logic edat, input logic [2:0] elvl,
                      input logic eov, input logic [CW-1:0] ecnt);
      vec_t e;
      e = '{r, v, f, g, c, etx, edat, elvl, eov, ecnt};
      tbl.push_back(e);
   endtask

   initial begin
      rst = 0; vld = 0; frm = '0; get = 1; clr = 0;
      // reset with request held, release without advance
      add(0,0,0,  1,0, IDLE,0,0,0,0);
      add(0,0,0,  1,0, IDLE,0,0,0,0);
      add(1,0,0,  1,0, IDLE,0,0,0,0);
      add(1,0,0,  0,0, IDLE,0,0,0,0);
      // single frame, requested three cycles later
      add(1,1,FX, 0,0, IDLE,0,1,0,0);
      add(1,0,0,  0,0, IDLE,0,1,0,0);
      add(1,0,0,  0,0, IDLE,0,1,0,0);
      add(1,0,0,  1,0, FX,1,0,0,0);
      add(1,0,0,  0,0, FX,1,0,0,0);
      // six writes, two dropped
      for (int k = 0; k < 6; k++)
         add(1,1,fr(k), 0,0, FX,1, 3'(k < 4 ? k+1 : 4), k >= 4, CW'(k >= 4 ? k-3 : 0));
      for (int k = 0; k < 4; k++) begin
         add(1,0,0, 1,0, fr(k),1,3'(3-k),1,2);
         add(1,0,0, 0,0, fr(k),1,3'(3-k),1,2);
      end
      add(1,0,0,  1,0, IDLE,0,0,1,2);
      add(1,0,0,  0,0, IDLE,0,0,1,2);
      // clear stats, fill, then write and advance together while full
      add(1,0,0,  0,1, IDLE,0,0,0,0);
      for (int k = 0; k < 4; k++) add(1,1,fr(k), 0,0, IDLE,0,3'(k+1),0,0);
      add(1,1,fr(4), 1,0, fr(0),1,4,0,0);
      add(1,0,0,  0,0, fr(0),1,4,0,0);

      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].v, tbl[i].f, tbl[i].g, tbl[i].c);
         chk_all(i, tbl[i].etx, tbl[i].edat, tbl[i].elvl, tbl[i].eov, tbl[i].ecnt);
      end

      // held request: exactly one advance with three queued
      cyc(1,0,0,1,0); chk_all(100, fr(1),1,3,0,0);
      cyc(1,0,0,0,0); chk_all(101, fr(1),1,3,0,0);
      for (int k = 0; k < 20; k++) begin
         cyc(1,0,0,1,0); chk_all(200+k, fr(2),1,2,0,0);
      end
      cyc(1,0,0,0,0);

      // drop counter saturation, then clear racing a drop
      cyc(0,0,0,0,0); chk_all(300, IDLE,0,0,0,0);
      for (int k = 0; k < 4; k++) cyc(1,1,fr(k),0,0);
      for (int k = 1; k <= 260; k++) begin
         cyc(1,1,fr(9),0,0);
         chk("satcnt", k, 128'(cnt), 128'(k > 255 ? 255 : k));
      end
      chk("satov", 0, 128'(ov), 128'(1));
      cyc(1,1,fr(9),0,1); chk_all(400, IDLE,0,4,0,0);
      cyc(1,1,fr(9),0,0); chk_all(401, IDLE,0,4,1,1);

      // random traffic against the model
      cyc(0,0,0,0,0);
      for (int k = 0; k < 3000; k++) begin
         cyc($urandom_range(0,99) != 0, $urandom_range(0,9) < 6,
             {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0,1) == 1, $urandom_range(0,31) == 0);
         chk_all(1000+k, m_tx, m_dat, 3'(m_q.size()), m_ov, m_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
